// File: rtl/test_host_pkg.sv
// rtl/test_host_pkg.sv - shared constants and state encoding for the program-run test host
package test_host_pkg;

   localparam int ADDR_W    = 8;
   localparam int DATA_W    = 8;
   localparam int MEM_DEPTH = 256;
   localparam int MCNT_W    = 9;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_INIT  = 3'd1;
   localparam state_t ST_REQ   = 3'd2;
   localparam state_t ST_WAIT  = 3'd3;
   localparam state_t ST_CHECK = 3'd4;
   localparam state_t ST_DONE  = 3'd5;

endpackage

// File: rtl/mem_window_checker.sv
// rtl/mem_window_checker.sv - sweeps a data-memory window against a golden image and counts mismatches
module mem_window_checker
   import test_host_pkg::*;
#(
   parameter int CHECK_BASE = 0,
   parameter int CHECK_LEN  = 64
) (
   input  logic              clk,
   input  logic              init,
   input  logic              clr,
   input  logic              go,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic [DATA_W-1:0] exp_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [MCNT_W-1:0] mismatch_cnt,
   output logic [ADDR_W-1:0] first_bad_addr,
   output logic              finished,
   output logic              clean
);

   localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(CHECK_BASE);
   localparam logic [MCNT_W-1:0] LAST_IDX  = MCNT_W'(CHECK_LEN - 1);

   logic              active_q, active_d;
   logic [MCNT_W-1:0] idx_q, idx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [MCNT_W-1:0] mcnt_q, mcnt_d;
   logic [ADDR_W-1:0] fbad_q, fbad_d;
   logic              seen_q, seen_d;
   logic              bad;

   always_comb begin
      active_d = active_q;
      idx_d    = idx_q;
      addr_d   = addr_q;
      mcnt_d   = mcnt_q;
      fbad_d   = fbad_q;
      seen_d   = seen_q;
      finished = 1'b0;
      bad      = active_q && (mem_rdata != exp_rdata);
      if (clr || go) begin
         mcnt_d = '0;
         fbad_d = '0;
         seen_d = 1'b0;
      end
      if (go) begin
         active_d = 1'b1;
         idx_d    = '0;
         addr_d   = BASE_ADDR;
      end else if (active_q) begin
         if (bad) begin
            mcnt_d = mcnt_q + 1'b1;
            if (!seen_q) begin
               fbad_d = addr_q;
               seen_d = 1'b1;
            end
         end
         // The address only advances between bytes, so the last byte never steps past 255.
         if (idx_q == LAST_IDX) begin
            active_d = 1'b0;
            finished = 1'b1;
         end else begin
            idx_d  = idx_q + 1'b1;
            addr_d = addr_q + 1'b1;
         end
      end
      clean = !seen_d;
   end

   always_ff @(posedge clk) begin
      if (init) begin
         active_q <= 1'b0;
         idx_q    <= '0;
         addr_q   <= '0;
         mcnt_q   <= '0;
         fbad_q   <= '0;
         seen_q   <= 1'b0;
      end else begin
         active_q <= active_d;
         idx_q    <= idx_d;
         addr_q   <= addr_d;
         mcnt_q   <= mcnt_d;
         fbad_q   <= fbad_d;
         seen_q   <= seen_d;
      end
   end

   assign mem_addr       = addr_q;
   assign mismatch_cnt   = mcnt_q;
   assign first_bad_addr = fbad_q;

endmodule

// File: rtl/test_host_ctrl.sv
// rtl/test_host_ctrl.sv - drives init/req into a program DUT, times its ack and checks its data memory
module test_host_ctrl
   import test_host_pkg::*;
#(
   parameter int INIT_CYCLES = 2,
   parameter int REQ_CYCLES  = 1,
   parameter int MAX_CYCLES  = 1000,
   parameter int CHECK_BASE  = 0,
   parameter int CHECK_LEN   = 64,
   parameter int CNT_W       = 32
) (
   input  logic              clk,
   input  logic              init,
   input  logic              start,
   output logic              dut_init,
   output logic              dut_req,
   input  logic              dut_ack,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic [DATA_W-1:0] exp_rdata,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              timeout,
   output logic [CNT_W-1:0]  cycle_cnt,
   output logic [MCNT_W-1:0] mismatch_cnt,
   output logic [ADDR_W-1:0] first_bad_addr
);

   localparam logic [31:0] INIT_LAST = 32'(INIT_CYCLES - 1);
   localparam logic [31:0] REQ_LAST  = 32'(REQ_CYCLES - 1);
   localparam logic [31:0] WAIT_LAST = 32'(MAX_CYCLES - 1);

   state_t           state_q, state_d;
   logic [31:0]      ph_q, ph_d;
   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
   logic             timeout_q, timeout_d;
   logic             pass_q, pass_d;
   logic             dut_init_q, dut_init_d;
   logic             dut_req_q, dut_req_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             chk_clr, chk_go, chk_finished, chk_clean;

   // ph_q counts cycles spent in INIT, REQ and WAIT; it is independent of the
   // saturating cycle_cnt so the timeout still fires when CNT_W is narrow.
   always_comb begin
      state_d     = state_q;
      ph_d        = ph_q;
      cycle_cnt_d = cycle_cnt_q;
      timeout_d   = timeout_q;
      pass_d      = pass_q;
      chk_clr     = 1'b0;
      chk_go      = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d     = ST_INIT;
               ph_d        = '0;
               cycle_cnt_d = '0;
               timeout_d   = 1'b0;
               pass_d      = 1'b0;
               chk_clr     = 1'b1;
            end
         end
         ST_INIT: begin
            if (ph_q == INIT_LAST) begin
               state_d = ST_REQ;
               ph_d    = '0;
            end else begin
               ph_d = ph_q + 32'd1;
            end
         end
         ST_REQ: begin
            if (ph_q == REQ_LAST) begin
               state_d = ST_WAIT;
               ph_d    = '0;
            end else begin
               ph_d = ph_q + 32'd1;
            end
         end
         ST_WAIT: begin
            if (cycle_cnt_q != {CNT_W{1'b1}}) begin
               cycle_cnt_d = cycle_cnt_q + 1'b1;
            end
            ph_d = ph_q + 32'd1;
            if (dut_ack) begin
               state_d = ST_CHECK;
               chk_go  = 1'b1;
            end else if (ph_q == WAIT_LAST) begin
               state_d   = ST_DONE;
               timeout_d = 1'b1;
               pass_d    = 1'b0;
            end
         end
         ST_CHECK: begin
            if (chk_finished) begin
               state_d = ST_DONE;
               pass_d  = chk_clean;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      dut_init_d = (state_d == ST_INIT);
      dut_req_d  = (state_d == ST_REQ);
      busy_d     = (state_d == ST_INIT) || (state_d == ST_REQ) ||
                   (state_d == ST_WAIT) || (state_d == ST_CHECK);
      done_d     = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (init) begin
         state_q     <= ST_IDLE;
         ph_q        <= '0;
         cycle_cnt_q <= '0;
         timeout_q   <= 1'b0;
         pass_q      <= 1'b0;
         dut_init_q  <= 1'b0;
         dut_req_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ph_q        <= ph_d;
         cycle_cnt_q <= cycle_cnt_d;
         timeout_q   <= timeout_d;
         pass_q      <= pass_d;
         dut_init_q  <= dut_init_d;
         dut_req_q   <= dut_req_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   mem_window_checker #(
      .CHECK_BASE (CHECK_BASE),
      .CHECK_LEN  (CHECK_LEN)
   ) u_checker (
      .clk            (clk),
      .init           (init),
      .clr            (chk_clr),
      .go             (chk_go),
      .mem_rdata      (mem_rdata),
      .exp_rdata      (exp_rdata),
      .mem_addr       (mem_addr),
      .mismatch_cnt   (mismatch_cnt),
      .first_bad_addr (first_bad_addr),
      .finished       (chk_finished),
      .clean          (chk_clean)
   );

   assign dut_init  = dut_init_q;
   assign dut_req   = dut_req_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign timeout   = timeout_q;
   assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_test_host_ctrl.sv
// tb/tb_test_host_ctrl.sv - directed bench: stub program DUT, memories and hand-computed results
module tb_test_host_ctrl;

   logic        clk = 1'b0;
   logic        init = 1'b1;
   logic        start = 1'b0;
   logic        dut_init, dut_req;
   logic        ack = 1'b0;
   logic [7:0]  mem_addr, mem_rdata, exp_rdata;
   logic        busy, done, pass, timeout;
   logic [31:0] cycle_cnt;
   logic [8:0]  mismatch_cnt;
   logic [7:0]  first_bad_addr;

   logic        start1 = 1'b0;
   logic        ack1 = 1'b1;
   logic        dut_init1, dut_req1;
   logic [7:0]  addr1, mem_rdata1, exp_rdata1;
   logic        busy1, done1, pass1, timeout1;
   logic [31:0] cycle_cnt1;
   logic [8:0]  mismatch_cnt1;
   logic [7:0]  first_bad_addr1;

   logic [7:0]  dut_mem [256];
   logic [7:0]  gold_mem [256];

   int n_checks = 0;
   int n_errors = 0;

   int ack_at = 40;
   int stub_cnt = 0;
   logic stub_armed = 1'b0;

   int n_busy, n_init, n_req, first_init, first_req, overlap, ack_ir, addr_chg;

   always #5 clk = ~clk;

   assign mem_rdata  = dut_mem[mem_addr];
   assign exp_rdata  = gold_mem[mem_addr];
   assign mem_rdata1 = dut_mem[addr1];
   assign exp_rdata1 = ~dut_mem[addr1];

   // Stub program: ack is a level, dropped only when it sees req, raised on the ack_at-th WAIT cycle.
   always @(posedge clk) begin
      if (dut_req) begin
         stub_armed <= 1'b1;
         stub_cnt   <= 0;
         ack        <= 1'b0;
      end else if (stub_armed) begin
         stub_cnt <= stub_cnt + 1;
         if (ack_at != 0 && stub_cnt + 2 == ack_at) ack <= 1'b1;
      end
   end

   test_host_ctrl dut (
      .clk(clk), .init(init), .start(start),
      .dut_init(dut_init), .dut_req(dut_req), .dut_ack(ack),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .exp_rdata(exp_rdata),
      .busy(busy), .done(done), .pass(pass), .timeout(timeout),
      .cycle_cnt(cycle_cnt), .mismatch_cnt(mismatch_cnt), .first_bad_addr(first_bad_addr)
   );

   test_host_ctrl #(.CHECK_BASE(192), .CHECK_LEN(64)) dut_hi (
      .clk(clk), .init(init), .start(start1),
      .dut_init(dut_init1), .dut_req(dut_req1), .dut_ack(ack1),
      .mem_addr(addr1), .mem_rdata(mem_rdata1), .exp_rdata(exp_rdata1),
      .busy(busy1), .done(done1), .pass(pass1), .timeout(timeout1),
      .cycle_cnt(cycle_cnt1), .mismatch_cnt(mismatch_cnt1), .first_bad_addr(first_bad_addr1)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic run0(input int budget);
      logic [7:0] prev;
      n_busy = 0; n_init = 0; n_req = 0; first_init = 0; first_req = 0;
      overlap = 0; ack_ir = 0; addr_chg = 0;
      @(negedge clk);
      prev  = mem_addr;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!done && n_busy < budget) begin
         n_busy++;
         if (dut_init) begin n_init++; if (first_init == 0) first_init = n_busy; end
         if (dut_req)  begin n_req++;  if (first_req == 0)  first_req  = n_busy; end
         if (dut_init && dut_req) overlap++;
         if (ack && (dut_init || dut_req)) ack_ir++;
         if (mem_addr != prev) addr_chg++;
         prev = mem_addr;
         @(negedge clk);
      end
      check_eq("done_reached", done, 1'b1);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_outs"}, {busy, done, pass, timeout, dut_init, dut_req}, 6'd0);
      check_eq({tag, "_cycle_cnt"}, cycle_cnt, 0);
      check_eq({tag, "_mismatch"}, mismatch_cnt, 0);
      check_eq({tag, "_first_bad"}, first_bad_addr, 0);
      check_eq({tag, "_mem_addr"}, mem_addr, 0);
   endtask

   initial begin
      int n;
      logic [7:0] prev;
      int wrap;
      for (int i = 0; i < 256; i++) begin
         dut_mem[i]  = 8'($urandom);
         gold_mem[i] = dut_mem[i];
      end

      repeat (3) @(negedge clk);
      init = 1'b0;
      check_all_zero("reset");
      check_eq("reset_hi_outs", {busy1, done1, pass1, timeout1, dut_init1, dut_req1}, 6'd0);

      // Clean run: 2 init, 1 req, ack on WAIT cycle 40, 64-byte check.
      run0(2000);
      check_eq("r1_busy_cycles", n_busy, 2 + 1 + 40 + 64);
      check_eq("r1_init_cycles", n_init, 2);
      check_eq("r1_req_cycles", n_req, 1);
      check_eq("r1_first_init", first_init, 1);
      check_eq("r1_first_req", first_req, 3);
      check_eq("r1_overlap", overlap, 0);
      check_eq("r1_cycle_cnt", cycle_cnt, 40);
      check_eq("r1_mismatch", mismatch_cnt, 0);
      check_eq("r1_pass", {pass, timeout, busy}, 3'b100);
      check_eq("r1_last_addr", mem_addr, 63);
      repeat (3) @(negedge clk);
      check_eq("r1_done_held", {done, pass}, 2'b11);

      // Corrupted bytes 5 and 63.
      dut_mem[5]  = dut_mem[5] ^ 8'hff;
      dut_mem[63] = dut_mem[63] ^ 8'h01;
      run0(2000);
      check_eq("r2_busy_cycles", n_busy, 107);
      check_eq("r2_mismatch", mismatch_cnt, 2);
      check_eq("r2_first_bad", first_bad_addr, 5);
      check_eq("r2_pass", pass, 1'b0);
      dut_mem[5]  = gold_mem[5];
      dut_mem[63] = gold_mem[63];

      // Stale ack still high from the previous run.
      check_eq("r3_ack_stale", ack, 1'b1);
      run0(2000);
      check_eq("r3_ack_in_init_req", ack_ir, 3);
      check_eq("r3_cycle_cnt", cycle_cnt, 40);
      check_eq("r3_results", {pass, mismatch_cnt, first_bad_addr}, {1'b1, 9'd0, 8'd0});

      // No ack: timeout after 1000 WAIT cycles, no sweep.
      ack_at = 0;
      run0(3000);
      check_eq("r4_busy_cycles", n_busy, 2 + 1 + 1000);
      check_eq("r4_timeout", {timeout, pass}, 2'b10);
      check_eq("r4_cycle_cnt", cycle_cnt, 1000);
      check_eq("r4_mismatch", mismatch_cnt, 0);
      check_eq("r4_addr_changes", addr_chg, 0);

      // Abort with init at CHECK index 10.
      ack_at = 40;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!(busy && mem_addr == 8'd10) && n < 500) begin
         n++;
         @(negedge clk);
      end
      check_eq("r5_reached_i10", busy && mem_addr == 8'd10, 1'b1);
      init = 1'b1;
      @(negedge clk);
      check_all_zero("r5_abort");
      init = 1'b0;
      repeat (5) @(negedge clk);
      check_eq("r5_stays_idle", {busy, done}, 2'b00);

      run0(2000);
      check_eq("r6_busy_cycles", n_busy, 107);
      check_eq("r6_results", {pass, timeout, cycle_cnt, mismatch_cnt}, {1'b1, 1'b0, 32'd40, 9'd0});

      // Top window, every byte wrong, ack already high on the first WAIT cycle.
      @(negedge clk);
      prev = addr1;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      n = 0; wrap = 0; addr_chg = 0;
      while (!done1 && n < 500) begin
         n++;
         if (addr1 != prev) begin
            addr_chg++;
            if (addr1 < prev || addr1 < 8'd192) wrap++;
         end
         prev = addr1;
         @(negedge clk);
      end
      check_eq("hi_done", done1, 1'b1);
      check_eq("hi_busy_cycles", n, 2 + 1 + 1 + 64);
      check_eq("hi_addr_steps", addr_chg, 64);
      check_eq("hi_wrap", wrap, 0);
      check_eq("hi_last_addr", addr1, 255);
      check_eq("hi_cycle_cnt", cycle_cnt1, 1);
      check_eq("hi_mismatch", mismatch_cnt1, 64);
      check_eq("hi_first_bad", first_bad_addr1, 192);
      check_eq("hi_pass", {pass1, timeout1}, 2'b00);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/test_host_ctrl.md
Name: test_host_ctrl

Overview:
- Initiator side of the program-run handshake: drives init/req into a program DUT, waits for ack, and measures run latency.
- After ack it sweeps a window of the DUT data memory. Each byte is compared against a golden memory, and the block reports pass/fail.
- Sits in the lab test harness, wrapping one DUT and its 256x8 data memory plus a golden-image memory. Both memories have combinational read.

Parameters:
- INIT_CYCLES, 2, cycles dut_init is held high per run (>=1)
- REQ_CYCLES, 1, cycles dut_req is held high after init (>=1)
- MAX_CYCLES, 1000, ack timeout in WAIT cycles (>=1)
- CHECK_BASE, 0, first data-memory address compared (0..255)
- CHECK_LEN, 64, bytes compared (1..256; CHECK_BASE+CHECK_LEN<=256)
- CNT_W, 32, cycle counter width

Ports:
- clk  in  1  clock
- init  in  1  synchronous active-high reset
- start  in  1  begin a run; sampled only in IDLE or DONE
- dut_init  out  1  reset to DUT
- dut_req  out  1  request/start to DUT
- dut_ack  in  1  DUT done; level, cleared by DUT on its init/req
- mem_addr  out  8  address to DUT data memory and golden memory
- mem_rdata  in  8  DUT data-memory read data, same cycle
- exp_rdata  in  8  golden read data, same cycle
- busy  out  1  run in progress
- done  out  1  result valid; held until next start or init
- pass  out  1  valid with done: no timeout and zero mismatches
- timeout  out  1  valid with done: ack never seen
- cycle_cnt  out  CNT_W  WAIT cycles consumed
- mismatch_cnt  out  9  mismatching bytes
- first_bad_addr  out  8  address of first mismatch; 0 if none

Behaviour:
- All outputs are registered. Init (sync) forces IDLE and clears every output, counter and flag to 0.
- Init mid-run aborts the run immediately, with no check and no done.
- States: IDLE -> INIT -> REQ -> WAIT -> CHECK -> DONE. WAIT may also go directly to DONE on timeout.
- IDLE:
  - Outputs idle.
  - start=1 -> INIT on the next edge. This clears cycle_cnt, mismatch_cnt, first_bad_addr, timeout, pass and done, and sets busy=1.
- INIT: dut_init=1 for exactly INIT_CYCLES cycles, then -> REQ.
- REQ:
  - dut_req=1 for exactly REQ_CYCLES cycles, immediately following init. There is no gap and no overlap.
  - dut_ack is ignored throughout INIT and REQ, because a stale ack from a previous run may still be high.
  - -> WAIT.
- WAIT:
  - dut_req=0. cycle_cnt increments each WAIT cycle, including the cycle in which ack is sampled high. If ack is high in the first WAIT cycle, cycle_cnt=1.
  - ack high -> CHECK.
  - If the MAX_CYCLES-th WAIT cycle completes with ack low -> DONE with timeout=1, cycle_cnt=MAX_CYCLES and pass=0. CHECK is skipped.
  - cycle_cnt saturates at all-ones and never wraps.
- CHECK:
  - mem_addr = CHECK_BASE+i for i = 0..CHECK_LEN-1, one byte per cycle, so CHECK takes exactly CHECK_LEN cycles.
  - Each cycle compares mem_rdata against exp_rdata.
  - On the first mismatch, latch first_bad_addr. Every mismatch increments mismatch_cnt, which has a max of 256 and fits 9 bits.
  - The address counter must not wrap past 255.
  - After the last byte -> DONE.
- DONE:
  - busy=0, done=1, pass=(!timeout && mismatch_cnt==0). All results are held.
  - start=1 -> INIT with results cleared, as from IDLE.
- start while busy is ignored. start and init together: init wins.
- Outside CHECK, mem_addr holds its last value. Outputs dut_init and dut_req are never both high.

Decomposition:
- Package test_host_pkg holds:
  - the state enum (IDLE, INIT, REQ, WAIT, CHECK, DONE)
  - the memory address width constant (8)
  - the memory depth constant (256)
  - the mismatch counter width constant (9)
- One sub-module is natural: mem_window_checker. It holds the address sweep, compare, mismatch count and first-bad latch, with go/finished handshake to the FSM.

Test Plan:
- Stub DUT with ack high from the 40th WAIT cycle; golden equals DUT memory; start pulse:
  - dut_init high 2 cycles, then dut_req high 1 cycle.
  - cycle_cnt=40, mismatch_cnt=0, pass=1, done=1.
  - Total start-to-done = 2+1+40+64 cycles.
- Same setup, but DUT bytes 5 and 63 corrupted -> mismatch_cnt=2, first_bad_addr=5, pass=0.
- Stub never acks, MAX_CYCLES=1000 -> timeout=1, cycle_cnt=1000, mismatch_cnt=0, pass=0. No CHECK: mem_addr never sweeps.
- Stub ack left high from the previous run at start -> ack ignored during INIT/REQ; the new run still measures cycle_cnt=40.
- init asserted during CHECK at i=10 -> next cycle IDLE with all outputs 0. A subsequent start runs cleanly to pass=1.
- CHECK_BASE=192, CHECK_LEN=64, all mismatching -> mem_addr sweeps 192..255 with no wrap, mismatch_cnt=64, first_bad_addr=192.
